// File: rtl/addsub_pipe.sv
// Chunk-serial pipelined adder/subtractor: each stage resolves CHUNK result bits
// using the carry registered by the previous stage; one global advance enable.
module addsub_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ALUFun0,
    input  logic             Sign,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negative,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    // rank k holds an operation about to have chunk k computed
    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] r_q   [STAGES];
    logic [WIDTH-1:0] r_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             sub_q [STAGES];
    logic             sub_d [STAGES];
    logic             sgn_q [STAGES];
    logic             sgn_d [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic [TAG_W-1:0] tag_d [STAGES];

    logic             ov_q, ov_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             z_q, z_d;
    logic             o_q, o_d;
    logic             n_q, n_d;
    logic [TAG_W-1:0] otag_q, otag_d;

    logic [CHUNK:0]   sum_w [STAGES];
    logic [CHUNK-1:0] bx;
    logic [WIDTH-1:0] s_full;
    logic             a_msb, b_msb, s_msb, cout, ovf;
    logic             adv;

    assign adv      = !ov_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        bx = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            bx       = b_q[k][k*CHUNK +: CHUNK] ^ {CHUNK{sub_q[k]}};
            sum_w[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]} + {1'b0, bx}
                     + {{CHUNK{1'b0}}, c_q[k]};
        end
    end

    always_comb begin
        s_full = r_q[LAST];
        s_full[LAST*CHUNK +: CHUNK] = sum_w[LAST][CHUNK-1:0];
        a_msb = a_q[LAST][WIDTH-1];
        b_msb = b_q[LAST][WIDTH-1];
        s_msb = s_full[WIDTH-1];
        cout  = sum_w[LAST][CHUNK];
        // unsigned subtract reports borrow, i.e. the inverse of the carry out
        if (sgn_q[LAST]) begin
            if (sub_q[LAST]) ovf = (a_msb != b_msb) && (s_msb != a_msb);
            else             ovf = (a_msb == b_msb) && (s_msb != a_msb);
        end else begin
            ovf = sub_q[LAST] ? !cout : cout;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            v_d[k]   = v_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            r_d[k]   = r_q[k];
            c_d[k]   = c_q[k];
            sub_d[k] = sub_q[k];
            sgn_d[k] = sgn_q[k];
            tag_d[k] = tag_q[k];
        end
        ov_d   = ov_q;
        s_d    = s_q;
        z_d    = z_q;
        o_d    = o_q;
        n_d    = n_q;
        otag_d = otag_q;

        if (adv) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                a_d[0]   = A;
                b_d[0]   = B;
                r_d[0]   = '0;
                c_d[0]   = ALUFun0;
                sub_d[0] = ALUFun0;
                sgn_d[0] = Sign;
                tag_d[0] = in_tag;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    a_d[k]   = a_q[k-1];
                    b_d[k]   = b_q[k-1];
                    r_d[k]   = r_q[k-1];
                    r_d[k][(k-1)*CHUNK +: CHUNK] = sum_w[k-1][CHUNK-1:0];
                    c_d[k]   = sum_w[k-1][CHUNK];
                    sub_d[k] = sub_q[k-1];
                    sgn_d[k] = sgn_q[k-1];
                    tag_d[k] = tag_q[k-1];
                end
            end
            ov_d = v_q[LAST];
            if (v_q[LAST]) begin
                s_d    = s_full;
                z_d    = (s_full == '0);
                o_d    = ovf;
                n_d    = sgn_q[LAST] & s_msb;
                otag_d = tag_q[LAST];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                sgn_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end
            ov_q   <= 1'b0;
            s_q    <= '0;
            z_q    <= 1'b0;
            o_q    <= 1'b0;
            n_q    <= 1'b0;
            otag_q <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                r_q[k]   <= r_d[k];
                c_q[k]   <= c_d[k];
                sub_q[k] <= sub_d[k];
                sgn_q[k] <= sgn_d[k];
                tag_q[k] <= tag_d[k];
            end
            ov_q   <= ov_d;
            s_q    <= s_d;
            z_q    <= z_d;
            o_q    <= o_d;
            n_q    <= n_d;
            otag_q <= otag_d;
        end
    end

    assign out_valid = ov_q;
    assign S         = s_q;
    assign Zero      = z_q;
    assign Overflow  = o_q;
    assign Negative  = n_q;
    assign out_tag   = otag_q;

endmodule
